// File: rtl/fwd_sel_unit.sv
// Forwarding/hazard control for the ID->EX boundary: tracks in-flight writers,
// registers EX operand-mux selects and inserts a single bubble on load-use.
module fwd_sel_unit #(
    parameter int REGW      = 5,
    parameter int NREG_ZERO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            flush,
    input  logic            hold,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b,
    output logic            stall_id,
    output logic            bubble_ex
);

    localparam logic [REGW-1:0] ZERO_IDX  = REGW'(NREG_ZERO);
    localparam logic [0:0]      ST_RUN    = 1'b0;
    localparam logic [0:0]      ST_LSTALL = 1'b1;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rd;
        logic            we;
        logic            is_load;
    } slot_t;

    slot_t      ex_slot, mem_slot, wb_slot;
    logic [0:0] state;

    logic       load_use;
    logic       issue;
    logic [1:0] sel_a, sel_b;

    function automatic logic hit(input slot_t s, input logic [REGW-1:0] src,
                                 input logic use_f);
        return s.valid & s.we & (s.rd == src) & (src != ZERO_IDX) & use_f;
    endfunction

    // Nearest producer wins: EX beats MEM beats WB.
    function automatic logic [1:0] pick(input logic he, input logic hm,
                                        input logic hw);
        if (he)      return 2'd1;
        else if (hm) return 2'd2;
        else if (hw) return 2'd3;
        else         return 2'd0;
    endfunction

    always_comb begin
        load_use = id_valid & ~flush & ex_slot.valid & ex_slot.is_load &
                   (hit(ex_slot, id_rs, id_use_rs) | hit(ex_slot, id_rt, id_use_rt));
        stall_id = (state == ST_RUN) & load_use;
        issue    = id_valid & ~flush & ~stall_id;
        sel_a    = pick(hit(ex_slot,  id_rs, id_use_rs),
                        hit(mem_slot, id_rs, id_use_rs),
                        hit(wb_slot,  id_rs, id_use_rs));
        sel_b    = pick(hit(ex_slot,  id_rt, id_use_rt),
                        hit(mem_slot, id_rt, id_use_rt),
                        hit(wb_slot,  id_rt, id_use_rt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            ex_fwd_a  <= 2'd0;
            ex_fwd_b  <= 2'd0;
            bubble_ex <= 1'b0;
            state     <= ST_RUN;
        end else if (!hold) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (issue) begin
                ex_slot  <= '{valid: 1'b1, rd: id_rd, we: id_we, is_load: id_is_load};
                ex_fwd_a <= sel_a;
                ex_fwd_b <= sel_b;
            end else begin
                ex_slot  <= '0;
                ex_fwd_a <= 2'd0;
                ex_fwd_b <= 2'd0;
            end
            bubble_ex <= stall_id | flush;
            // flush already masks stall_id, so a flushed hazard stays in RUN.
            state     <= stall_id ? ST_LSTALL : ST_RUN;
        end
    end

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed bench for fwd_sel_unit: a history-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_fwd_sel_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt, id_we, id_is_load, flush, hold;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic       stall_id, bubble_ex;

    int checks = 0;
    int errors = 0;

    fwd_sel_unit #(.REGW(5), .NREG_ZERO(0)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .hold(hold), .ex_fwd_a(ex_fwd_a),
        .ex_fwd_b(ex_fwd_b), .stall_id(stall_id), .bubble_ex(bubble_ex)
    );

    always #5 clk = ~clk;

    // Reference model: hist[d] is the instruction issued d+1 advances ago.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ent_t;

    ent_t       hist [3];
    logic [1:0] m_a, m_b;
    logic       m_bub;

    function automatic logic writes(input ent_t e, input logic [4:0] src, input logic u);
        return e.v && e.we && e.rd == src && src != 5'd0 && u;
    endfunction

    function automatic logic [1:0] dist_sel(input logic [4:0] src, input logic u);
        for (int d = 0; d < 3; d++)
            if (writes(hist[d], src, u)) return 2'(d + 1);
        return 2'd0;
    endfunction

    function automatic logic exp_stall();
        return id_valid && !flush && hist[0].v && hist[0].ld &&
               (writes(hist[0], id_rs, id_use_rs) || writes(hist[0], id_rt, id_use_rt));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] <= '0;
            m_a <= 2'd0; m_b <= 2'd0; m_bub <= 1'b0;
        end else if (!hold) begin
            automatic logic st = exp_stall();
            automatic logic go = id_valid && !flush && !st;
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= go ? ent_t'{v: 1'b1, rd: id_rd, we: id_we, ld: id_is_load} : ent_t'('0);
            m_a     <= go ? dist_sel(id_rs, id_use_rs) : 2'd0;
            m_b     <= go ? dist_sel(id_rt, id_use_rt) : 2'd0;
            m_bub   <= st || flush;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_fwd_a", ex_fwd_a, m_a);
        chk("model_fwd_b", ex_fwd_b, m_b);
        chk("model_bubble", bubble_ex, m_bub);
        chk("model_stall", stall_id, exp_stall());
    end

    // Applies one ID presentation after the edge; caller checks 1 time unit later.
    task automatic step(input bit v, input int rs, input int rt, input bit ur, input bit ut,
                        input int rd, input bit we, input bit ld,
                        input bit fl = 1'b0, input bit hd = 1'b0);
        @(posedge clk);
        #2;
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = ur; id_use_rt = ut;
        id_rd = 5'(rd); id_we = we; id_is_load = ld; flush = fl; hold = hd;
        #1;
    endtask

    task automatic nop(input int n = 1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_rd = 0; id_we = 0; id_is_load = 0; flush = 0; hold = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_fwd_a", ex_fwd_a, 0);
        chk("reset_bubble", bubble_ex, 0);
        chk("reset_stall", stall_id, 0);
        #1 rst_n = 1'b1;

        // add r3,r1,r2 ; sub r5,r3,r4
        step(1, 1, 2, 1, 1, 3, 1, 0);
        step(1, 3, 4, 1, 1, 5, 1, 0);
        chk("b2b_stall", stall_id, 0);
        nop();
        chk("b2b_fwd_a", ex_fwd_a, 1);
        chk("b2b_fwd_b", ex_fwd_b, 0);
        nop(3);

        // two-apart -> 2
        step(1, 1, 2, 1, 1, 8, 1, 0); nop();
        step(1, 8, 0, 1, 0, 12, 1, 0); nop();
        chk("two_apart_a", ex_fwd_a, 2);
        nop(3);
        // three-apart -> 3 on B
        step(1, 1, 2, 1, 1, 9, 1, 0); nop(2);
        step(1, 0, 9, 0, 1, 12, 1, 0); nop();
        chk("three_apart_b", ex_fwd_b, 3);
        nop(3);
        // four-apart -> 0
        step(1, 1, 2, 1, 1, 10, 1, 0); nop(3);
        step(1, 10, 0, 1, 0, 12, 1, 0); nop();
        chk("four_apart_a", ex_fwd_a, 0);
        nop(3);

        // lw r2 ; add r6,r2,r2
        step(1, 1, 0, 1, 0, 2, 1, 1);
        step(1, 2, 2, 1, 1, 6, 1, 0);
        chk("lu_stall", stall_id, 1);
        step(1, 2, 2, 1, 1, 6, 1, 0);
        chk("lu_stall_once", stall_id, 0);
        chk("lu_bubble", bubble_ex, 1);
        chk("lu_bubble_sel", ex_fwd_a, 0);
        nop();
        chk("lu_fwd_a", ex_fwd_a, 2);
        chk("lu_fwd_b", ex_fwd_b, 2);
        chk("lu_no_bubble", bubble_ex, 0);
        nop(3);

        // priority and r0
        step(1, 1, 2, 1, 1, 7, 1, 0);
        step(1, 1, 2, 1, 1, 7, 1, 0);
        step(1, 7, 0, 1, 0, 12, 1, 0); nop();
        chk("prio_a", ex_fwd_a, 1);
        step(1, 1, 2, 1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 12, 1, 0); nop();
        chk("zero_a", ex_fwd_a, 0);
        chk("zero_b", ex_fwd_b, 0);
        nop(3);

        // flush during hazard
        step(1, 1, 0, 1, 0, 2, 1, 1);
        step(1, 2, 0, 1, 0, 6, 1, 0, 1);
        chk("flush_stall", stall_id, 0);
        step(1, 2, 0, 1, 0, 6, 1, 0);
        chk("flush_bubble", bubble_ex, 1);
        chk("flush_run", stall_id, 0);
        nop();
        chk("flush_next_a", ex_fwd_a, 2);
        nop(3);

        // hold for 3 edges inside LSTALL
        step(1, 1, 0, 1, 0, 2, 1, 1);
        step(1, 2, 0, 1, 0, 6, 1, 0);
        chk("hold_pre_stall", stall_id, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 2, 0, 1, 0, 6, 1, 0, 0, 1);
            chk("hold_bubble", bubble_ex, 1);
            chk("hold_stall", stall_id, 0);
        end
        step(1, 2, 0, 1, 0, 6, 1, 0);
        chk("hold_frozen", bubble_ex, 1);
        nop();
        chk("hold_resolved_a", ex_fwd_a, 2);
        chk("hold_resolved_bub", bubble_ex, 0);
        nop(3);

        // async reset mid-stall with a live nonzero select
        step(1, 1, 2, 1, 1, 11, 1, 0);
        step(1, 11, 0, 1, 0, 2, 1, 1);
        step(1, 2, 0, 1, 0, 6, 1, 0);
        chk("rst_pre_a", ex_fwd_a, 1);
        chk("rst_pre_stall", stall_id, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_a", ex_fwd_a, 0);
        chk("rst_async_stall", stall_id, 0);
        chk("rst_async_bub", bubble_ex, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        nop(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
